// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane
// geometry and the default wait-state count.
package dmem_pkg;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int BYTE_W          = 8;
  localparam int LANES           = 4;
  localparam int DATA_W          = BYTE_W * LANES;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int CNT_W           = 4;

  // Initial value of the wait counter for a given wait-state setting.
  function automatic logic [CNT_W-1:0] wait_init(input int wait_cycles);
    return (wait_cycles > 0) ? CNT_W'(wait_cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit storage with four byte-lane write enables and a registered
// (synchronous) read port. Contents are never cleared by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LANES-1:0]  wr_be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Byte-lane writes: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem_q[addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Synchronous read of the full word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: captures a request, waits WAIT_CYCLES, performs the
// access and returns a one-cycle ack with registered read data.
// Optional feature macro: DMEM_WCOUNT_EN adds a saturating wr_count output
// counting acknowledged in-range writes with a non-zero byte enable.
//
// Handshake: the requester raises req with we/be/addr/wdata stable and keeps
// them until ack. The request is captured on the first rising edge in IDLE
// with req high; ack is high for exactly one cycle, during which the FSM is
// back in IDLE, so a req still high then starts the next access on the edge
// that ends ack.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
`ifdef DMEM_WCOUNT_EN
  output logic [15:0]       wr_count,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] WAIT_INIT = wait_init(WAIT_CYCLES);

  dmem_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [LANES-1:0]  be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              in_range_q;
  logic              ack_q;
  logic              err_q;
  logic              rd_valid_q;

  logic              in_range_d;
  logic              arr_wr_en;
  logic              arr_rd_en;
  logic [DATA_W-1:0] arr_rd_data;

  // Address range check on the live request, latched at capture.
  always_comb begin
    in_range_d = ({{(32-ADDR_W){1'b0}}, addr} < 32'(DEPTH));
  end

  // The access itself happens on the edge that leaves RESP.
  assign arr_wr_en = (state_q == RESP) && we_q && in_range_q;
  assign arr_rd_en = (state_q == RESP) && !we_q && in_range_q;

  // Request FSM with registered ack/err and read-data qualifier.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            we_q       <= we;
            be_q       <= be;
            addr_q     <= addr;
            wdata_q    <= wdata;
            in_range_q <= in_range_d;
            if (WAIT_CYCLES > 0) begin
              cnt_q   <= WAIT_INIT;
              state_q <= WAIT;
            end else begin
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          ack_q      <= 1'b1;
          err_q      <= !in_range_q;
          rd_valid_q <= !we_q && in_range_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DMEM_WCOUNT_EN
  logic [15:0] wr_count_q;

  // Saturating count of effective in-range writes, bumped with their ack.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_count_q <= '0;
    end else if (arr_wr_en && (be_q != '0) && (wr_count_q != 16'hFFFF)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .wr_en  (arr_wr_en),
    .wr_be  (be_q),
    .addr   (addr_q),
    .wr_data(wdata_q),
    .rd_en  (arr_rd_en),
    .rd_data(arr_rd_data)
  );

  assign rdata     = rd_valid_q ? arr_rd_data : '0;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (DEPTH=48, WAIT_CYCLES=1): directed steps plus
// random accesses checked against a word-array reference model.
module tb_dmem_responder;

  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 48;
  localparam int WAIT_C  = 1;
  localparam int EXP_LAT = WAIT_C + 1;

  logic              clk;
  logic              nrst;
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              busy;
  logic              err;
  logic [1:0]        dbg_state;
`ifdef DMEM_WCOUNT_EN
  logic [15:0]       wr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  int          wcount_m = 0;

  dmem_responder #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_C)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .req      (req),
    .we       (we),
    .be       (be),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .err      (err),
`ifdef DMEM_WCOUNT_EN
    .wr_count (wr_count),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for capture and ack; returns cycles from capture edge to ack edge.
  task automatic wait_ack(input string tag, output int lat, output logic [31:0] rd,
                          output logic er);
    lat = 0;
    @(posedge clk); #1;
    check({tag, " ack_low_at_capture"}, 32'(ack), 32'd0);
    check({tag, " busy_after_capture"}, 32'(busy), 32'd1);
    while (ack !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    er = err;
    check({tag, " busy_in_ack"}, 32'(busy), 32'd0);
  endtask

  function automatic void model_apply(input logic w, input logic [3:0] b,
                                      input int a, input logic [31:0] d);
    if (w && a < DEPTH) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mem_m[a][i*8 +: 8] = d[i*8 +: 8];
      end
      if (b != 4'h0 && wcount_m < 65535) wcount_m++;
    end
  endfunction

  // One access; keep_req leaves req high for a back-to-back follow-up.
  task automatic do_access(input string tag, input logic w, input logic [3:0] b,
                           input int a, input logic [31:0] d, input bit keep_req);
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        exp_err;
    logic [31:0] exp_rd;
    exp_err = (a >= DEPTH);
    exp_rd  = (!w && !exp_err) ? mem_m[a] : 32'h0;
    req   = 1'b1;
    we    = w;
    be    = b;
    addr  = ADDR_W'(a);
    wdata = d;
    wait_ack(tag, lat, rd, er);
    check({tag, " latency"}, 32'(lat), 32'(EXP_LAT));
    check({tag, " err"}, 32'(er), 32'(exp_err));
    check({tag, " rdata"}, rd, exp_rd);
    model_apply(w, b, a, d);
    // Scramble inputs after ack to show only the captured values matter.
    we    = 1'($urandom);
    be    = 4'($urandom);
    wdata = $urandom;
    if (!keep_req) begin
      req = 1'b0;
      @(posedge clk); #1;
      check({tag, " ack_single_cycle"}, 32'(ack), 32'd0);
    end
  endtask

  initial begin
    req   = 1'b0;
    we    = 1'b0;
    be    = 4'h0;
    addr  = '0;
    wdata = '0;
    nrst  = 1'b0;

    // Reset state
    #1;
    check("reset ack", 32'(ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;

    // Preload every word so the model is fully defined.
    for (int a = 0; a < DEPTH; a++) begin
      do_access("preload", 1'b1, 4'hF, a, $urandom, 1'b0);
    end

    // Full-word write then read of addr 5
    do_access("wr5_full", 1'b1, 4'hF, 5, 32'hDEADBEEF, 1'b0);
    do_access("rd5_full", 1'b0, 4'h0, 5, 32'h0, 1'b0);
    check("model5_full", mem_m[5], 32'hDEADBEEF);

    // Lane-0 store over DEADBEEF
    do_access("wr5_byte", 1'b1, 4'b0001, 5, 32'h000000AA, 1'b0);
    do_access("rd5_byte", 1'b0, 4'h0, 5, 32'h0, 1'b0);
    check("model5_byte", mem_m[5], 32'hDEADBEAA);

    // be=0 write leaves memory alone
    do_access("wr9_be0", 1'b1, 4'h0, 9, 32'hFFFFFFFF, 1'b0);
    do_access("rd9_be0", 1'b0, 4'h0, 9, 32'h0, 1'b0);

    // Out-of-range read and write; aliased word stays intact
    do_access("rd63_oor", 1'b0, 4'h0, 63, 32'h0, 1'b0);
    do_access("wr50_oor", 1'b1, 4'hF, 50, 32'hCAFEF00D, 1'b0);
    do_access("rd2_alias", 1'b0, 4'h0, 2, 32'h0, 1'b0);
    do_access("rd50_alias", 1'b0, 4'h0, 50 - 32, 32'h0, 1'b0);

    // Back-to-back reads with req held high
    do_access("b2b_rd1", 1'b0, 4'h0, 1, 32'h0, 1'b1);
    do_access("b2b_rd2", 1'b0, 4'h0, 2, 32'h0, 1'b1);
    do_access("b2b_rd3", 1'b0, 4'h0, 3, 32'h0, 1'b0);

    // Reset during WAIT of a write to addr 7 aborts it
    req   = 1'b1;
    we    = 1'b1;
    be    = 4'hF;
    addr  = ADDR_W'(7);
    wdata = 32'h12345678;
    @(posedge clk); #1;
    check("abort in_wait", 32'(dbg_state), 32'd1);
    nrst = 1'b0;
    #1;
    check("abort state", 32'(dbg_state), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort no_ack_in_reset", 32'(ack), 32'd0);
      if (i == 1) nrst = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort no_ack_after", 32'(ack), 32'd0);
    end
    do_access("rd7_after_abort", 1'b0, 4'h0, 7, 32'h0, 1'b0);

    // Read-after-write in consecutive transactions, held req
    do_access("raw_wr", 1'b1, 4'b1100, 11, 32'hA5A55A5A, 1'b1);
    do_access("raw_rd", 1'b0, 4'h0, 11, 32'h0, 1'b0);

    // Random accesses across in-range and out-of-range addresses
    for (int n = 0; n < 80; n++) begin
      do_access("rand", 1'($urandom), 4'($urandom_range(0, 15)),
                $urandom_range(0, 63), $urandom, 1'($urandom_range(0, 1)));
    end
    req = 1'b0;
    @(posedge clk); #1;

`ifdef DMEM_WCOUNT_EN
    check("wr_count", 32'(wr_count), 32'(wcount_m));
`endif

    // Final sweep of all words against the model
    for (int a = 0; a < DEPTH; a++) begin
      do_access("sweep", 1'b0, 4'h0, a, 32'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed 32-bit data memory acting as the responder for the core's load/store port.
- Replaces the four zero-latency byte-lane data memories with one memory that uses a request/acknowledge handshake and programmable wait states.
- Per-byte write enables preserve store-byte (lane 0) and store-word (all lanes) semantics.
- Read data is registered and presented with the acknowledge.

Parameters:
- ADDR_W, 6, word-address width.
- DEPTH, 64, number of implemented 32-bit words; must be <= 2**ADDR_W.
- WAIT_CYCLES, 1, extra cycles between request capture and acknowledge; range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- req  in  1  access request; held high with addr/we/be/wdata stable until ack.
- we  in  1  1 = write (store), 0 = read (load).
- be  in  4  byte-lane write enables; be[0] = bits 7:0 ... be[3] = bits 31:24; ignored on reads.
- addr  in  ADDR_W  word address.
- wdata  in  32  store data.
- rdata  out  32  load data; valid only while ack is high.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high in WAIT and RESP states.
- err  out  1  high with ack when addr >= DEPTH.

Behaviour:
- Reset (nrst low, asynchronous):
  - state = IDLE; ack = 0, err = 0, busy = 0, rdata = 0, wait counter = 0.
  - Memory array is not cleared.
- States:
  - IDLE: on a rising edge with req = 1, latch we/be/addr/wdata. If WAIT_CYCLES > 0, go to WAIT with cnt = WAIT_CYCLES - 1; otherwise go to RESP.
  - WAIT: cnt decrements each cycle. When cnt == 0 at the edge, go to RESP.
  - RESP: at the edge leaving RESP, perform the access, drive ack = 1 for exactly one cycle, and return to IDLE.
- Latency: req sampled high at edge N → ack high during the cycle after edge N + WAIT_CYCLES + 1.
- Write: for each i with be[i] = 1, mem[addr][8i+7:8i] <= wdata[8i+7:8i]; other lanes are unchanged.
  - be = 0: acknowledged with no change to memory.
  - rdata = 0 on write acks.
- Read: rdata = mem[addr] (all 32 bits) registered at the RESP edge.
- Out of range (addr >= DEPTH): ack = 1 and err = 1, no write, rdata = 0.
- Handshake:
  - The requester holds inputs stable until ack. Inputs are latched at capture, so later changes are ignored.
  - req still high in the ack cycle starts a new access at the edge that ends ack, so back-to-back accesses have one IDLE sample cycle.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset mid-operation (WAIT or RESP before its completing edge): the access is aborted, no write occurs, and no ack is issued.
- busy = (state != IDLE).

Optional Feature:
- Macro: DMEM_WCOUNT_EN.
- Defined:
  - Adds output wr_count[15:0], reset to 0.
  - Increments by 1 at every ack of an in-range write with be != 0.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (dmem_pkg):
  - State encoding constants: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - Lane width constant: BYTE_W = 8.
  - Default WAIT_CYCLES.
- One natural sub-module, dmem_array: DEPTH x 32 storage with four byte-lane write enables and a synchronous read port.
- The FSM, counter and handshake stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=1: write addr 5, be=4'hF, wdata=32'hDEADBEEF, then read addr 5 → ack exactly 2 cycles after req capture each time; rdata=32'hDEADBEEF, err=0.
- Write addr 5, be=4'b0001, wdata=32'h000000AA over 32'hDEADBEEF → read returns 32'hDEADBEAA.
- Read addr 63 with DEPTH=48 → ack=1, err=1, rdata=0, memory unchanged.
- req held high for 3 consecutive reads of addrs 1, 2, 3 → three single-cycle ack pulses separated by the fixed latency; busy low only in the capture cycles.
- Assert nrst low during WAIT of a write to addr 7 (be=4'hF, wdata=32'h12345678) → no ack, state IDLE; a subsequent read of addr 7 returns its prior value.
- DMEM_WCOUNT_EN defined: 3 writes (one with be=0), 1 read → wr_count=2; preload 16'hFFFF then one write → stays 16'hFFFF.
